// File: rtl/sc_bi_stream_decoder_if.sv
// ============================================================================
// Module   : sc_bi_stream_decoder_if
// Brief    : Stream input, start/busy control and result handshake bundle
//            for the bipolar stochastic stream decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sc_bi_stream_decoder_if #(
    parameter int LOG_LEN = 8
);
    logic                 start;
    logic                 in_valid;
    logic                 x;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready;
    logic [LOG_LEN:0]     ones;
    logic [LOG_LEN+1:0]   y;

    modport master (
        output start, in_valid, x, out_ready,
        input  busy, out_valid, ones, y
    );

    modport slave (
        input  start, in_valid, x, out_ready,
        output busy, out_valid, ones, y
    );
endinterface

`default_nettype wire

// File: rtl/sc_bi_stream_decoder.sv
// ============================================================================
// Module   : sc_bi_stream_decoder
// Brief    : Counts ones over a 2^LOG_LEN-bit bipolar stochastic window and
//            reports y = 2*ones - L on a valid/ready result handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_bi_stream_decoder #(
    parameter int LOG_LEN = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    sc_bi_stream_decoder_if.slave  bus
);
    localparam logic [LOG_LEN:0]   C_LAST  = (LOG_LEN+1)'((1 << LOG_LEN) - 1);
    localparam logic [LOG_LEN:0]   C_ONE   = (LOG_LEN+1)'(1);
    localparam logic [LOG_LEN+1:0] C_LEN_Y = (LOG_LEN+2)'(1 << LOG_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state, w_state_next;
    logic [LOG_LEN:0]   r_cnt, w_cnt_next;
    logic [LOG_LEN:0]   r_acc, w_acc_next;
    logic [LOG_LEN:0]   r_ones, w_ones_next;
    logic [LOG_LEN+1:0] r_y, w_y_next;
    logic               r_out_valid, w_out_valid_next;
    logic [LOG_LEN:0]   w_sum;

    // acc is bounded by L, so the sum and the doubled sum never overflow
    assign w_sum = r_acc + {{LOG_LEN{1'b0}}, bus.x};

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_acc_next       = r_acc;
        w_ones_next      = r_ones;
        w_y_next         = r_y;
        w_out_valid_next = r_out_valid;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_cnt_next   = '0;
                    w_acc_next   = '0;
                    w_state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.in_valid) begin
                    w_acc_next = w_sum;
                    w_cnt_next = r_cnt + C_ONE;
                    if (r_cnt == C_LAST) begin
                        w_ones_next      = w_sum;
                        w_y_next         = {w_sum, 1'b0} - C_LEN_Y;
                        w_out_valid_next = 1'b1;
                        w_state_next     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (r_out_valid && bus.out_ready) begin
                    w_out_valid_next = 1'b0;
                    if (bus.start) begin
                        w_cnt_next   = '0;
                        w_acc_next   = '0;
                        w_state_next = S_ACCUM;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_out_valid_next = 1'b0;
                w_state_next     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_ones      <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_acc       <= w_acc_next;
            r_ones      <= w_ones_next;
            r_y         <= w_y_next;
            r_out_valid <= w_out_valid_next;
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.ones      = r_ones;
    assign bus.y         = r_y;
endmodule

`default_nettype wire

// File: tb/tb_sc_bi_stream_decoder.sv
// ============================================================================
// Module   : tb_sc_bi_stream_decoder
// Brief    : Directed vector-table bench for LOG_LEN=4 and LOG_LEN=1 decoders.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sc_bi_stream_decoder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sc_bi_stream_decoder_if #(.LOG_LEN(4)) bus_a ();
    sc_bi_stream_decoder_if #(.LOG_LEN(1)) bus_b ();

    sc_bi_stream_decoder #(.LOG_LEN(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    sc_bi_stream_decoder #(.LOG_LEN(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    // one row = inputs for one cycle, expected outputs just after that edge
    typedef struct {
        bit         sel;
        logic       start, in_valid, x, out_ready;
        logic       busy, out_valid;
        logic [4:0] ones;
        logic [5:0] y;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void add(bit sel, logic st, logic iv, logic xb, logic rdy,
                                logic b, logic ov, logic [4:0] o, logic [5:0] yy);
        vec_t v;
        v.sel = sel; v.start = st; v.in_valid = iv; v.x = xb; v.out_ready = rdy;
        v.busy = b; v.out_valid = ov; v.ones = o; v.y = yy;
        vq.push_back(v);
    endfunction

    // start row, then 16 accepted bits (bit 0 first), last one completes
    function automatic void add_window(logic [15:0] bits, logic [4:0] po, logic [5:0] py,
                                       logic [4:0] no, logic [5:0] ny);
        add(0, 1, 0, 0, 0, 1, 0, po, py);
        for (int k = 0; k < 16; k++)
            add(0, 0, 1, bits[k], 0, 1, (k == 15), (k == 15) ? no : po, (k == 15) ? ny : py);
        add(0, 0, 0, 0, 1, 0, 0, no, ny);
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_a.start = 0; bus_a.in_valid = 0; bus_a.x = 0; bus_a.out_ready = 0;
        bus_b.start = 0; bus_b.in_valid = 0; bus_b.x = 0; bus_b.out_ready = 0;
    endtask

    task automatic run_table(string tag);
        foreach (vq[i]) begin
            idle_inputs();
            if (!vq[i].sel) begin
                bus_a.start = vq[i].start; bus_a.in_valid = vq[i].in_valid;
                bus_a.x = vq[i].x; bus_a.out_ready = vq[i].out_ready;
            end else begin
                bus_b.start = vq[i].start; bus_b.in_valid = vq[i].in_valid;
                bus_b.x = vq[i].x; bus_b.out_ready = vq[i].out_ready;
            end
            @(posedge clk);
            #1;
            if (!vq[i].sel) begin
                check($sformatf("%s[%0d] busy", tag, i), {7'b0, bus_a.busy}, {7'b0, vq[i].busy});
                check($sformatf("%s[%0d] out_valid", tag, i), {7'b0, bus_a.out_valid}, {7'b0, vq[i].out_valid});
                check($sformatf("%s[%0d] ones", tag, i), {3'b0, bus_a.ones}, {3'b0, vq[i].ones});
                check($sformatf("%s[%0d] y", tag, i), {2'b0, bus_a.y}, {2'b0, vq[i].y});
            end else begin
                check($sformatf("%s[%0d] busy", tag, i), {7'b0, bus_b.busy}, {7'b0, vq[i].busy});
                check($sformatf("%s[%0d] out_valid", tag, i), {7'b0, bus_b.out_valid}, {7'b0, vq[i].out_valid});
                check($sformatf("%s[%0d] ones", tag, i), {6'b0, bus_b.ones}, {6'b0, vq[i].ones[1:0]});
                check($sformatf("%s[%0d] y", tag, i), {5'b0, bus_b.y}, {5'b0, vq[i].y[2:0]});
            end
        end
        vq.delete();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {7'b0, bus_a.busy}, 8'd0);
        check("reset out_valid", {7'b0, bus_a.out_valid}, 8'd0);
        check("reset ones", {3'b0, bus_a.ones}, 8'd0);
        check("reset y", {2'b0, bus_a.y}, 8'd0);
        rst = 1'b0;

        // idle ignores stream bits; all ones, all zeros, alternating
        add(0, 0, 1, 1, 0, 0, 0, 5'd0, 6'd0);
        add_window(16'hFFFF, 5'd0, 6'd0, 5'd16, 6'd16);
        add_window(16'h0000, 5'd16, 6'd16, 5'd0, 6'h30);
        add_window(16'h5555, 5'd0, 6'h30, 5'd8, 6'd0);
        run_table("basic");

        // 12 ones, 4 zeros with stalls of 1, 3 and 7 cycles presenting x=1
        add(0, 1, 0, 0, 0, 1, 0, 5'd8, 6'd0);
        for (int k = 0; k < 16; k++) begin
            add(0, 0, 1, (k < 12), 0, 1, (k == 15), (k == 15) ? 5'd12 : 5'd8, (k == 15) ? 6'd8 : 6'd0);
            if (k == 2)  add(0, 0, 0, 1, 0, 1, 0, 5'd8, 6'd0);
            if (k == 7)  for (int s = 0; s < 3; s++) add(0, 0, 0, 1, 0, 1, 0, 5'd8, 6'd0);
            if (k == 12) for (int s = 0; s < 7; s++) add(0, 0, 0, 1, 0, 1, 0, 5'd8, 6'd0);
        end
        // hold under backpressure with start pulses, then back-to-back restart
        for (int k = 0; k < 10; k++) add(0, (k % 2 == 1), 1, 0, 0, 1, 1, 5'd12, 6'd8);
        add(0, 1, 0, 0, 1, 1, 0, 5'd12, 6'd8);
        for (int k = 0; k < 16; k++)
            add(0, 0, 1, 1, 0, 1, (k == 15), (k == 15) ? 5'd16 : 5'd12, (k == 15) ? 6'd16 : 6'd8);
        add(0, 0, 0, 0, 1, 0, 0, 5'd16, 6'd16);
        run_table("stall");

        // abort a window after 9 bits with an asynchronous reset
        add(0, 1, 0, 0, 0, 1, 0, 5'd16, 6'd16);
        for (int k = 0; k < 9; k++) add(0, 0, 1, 1, 0, 1, 0, 5'd16, 6'd16);
        run_table("abort");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async rst busy", {7'b0, bus_a.busy}, 8'd0);
        check("async rst out_valid", {7'b0, bus_a.out_valid}, 8'd0);
        check("async rst ones", {3'b0, bus_a.ones}, 8'd0);
        check("async rst y", {2'b0, bus_a.y}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        add(0, 0, 1, 1, 0, 0, 0, 5'd0, 6'd0);
        add_window(16'h000F, 5'd0, 6'd0, 5'd4, 6'h38);
        run_table("post_rst");

        // LOG_LEN=1: start cycle bit ignored, then 1,0 and back-to-back 1,1
        add(1, 1, 1, 1, 0, 1, 0, 5'd0, 6'd0);
        add(1, 0, 1, 1, 0, 1, 0, 5'd0, 6'd0);
        add(1, 0, 1, 0, 0, 1, 1, 5'd1, 6'd0);
        add(1, 1, 0, 0, 1, 1, 0, 5'd1, 6'd0);
        add(1, 0, 1, 1, 0, 1, 0, 5'd1, 6'd0);
        add(1, 0, 1, 1, 0, 1, 1, 5'd2, 6'd2);
        add(1, 0, 0, 0, 1, 0, 0, 5'd2, 6'd2);
        run_table("len2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
